// File: rtl/mat_pkg.sv
// ============================================================================
// Module : mat_pkg
// Shared op encodings and word width for the matrix unit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mat_pkg;

  localparam int MAT_WORD_BITS = 32;

  typedef enum logic [2:0] {
    RD_NONE       = 3'd0,
    RD_ROW        = 3'd1,
    RD_COL        = 3'd2,
    RD_DIAG       = 3'd3,
    RD_DIAG_SPLIT = 3'd4
  } MatDataReadOp_t;

  typedef enum logic [2:0] {
    WR_NONE       = 3'd0,
    WR_ROW        = 3'd1,
    WR_COL        = 3'd2,
    WR_DIAG       = 3'd3,
    WR_DIAG_SPLIT = 3'd4
  } MatDataWriteOp_t;

endpackage

`default_nettype wire

// File: rtl/mat_cache_lane_map.sv
// ============================================================================
// Module : mat_cache_lane_map
// Maps one vector lane of an access op to (matrix, row, col, enable).
// Diagonal ops exist only when MAT_CACHE_DIAG_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mat_cache_lane_map
  import mat_pkg::*;
#(
  parameter int WIDTH           = 16,
  parameter int CACHE_SIZE      = 8,
  parameter int WIDTH_ADDR_SIZE = $clog2(WIDTH),
  parameter int CACHE_ADDR_SIZE = $clog2(CACHE_SIZE)
) (
  input  logic [2:0]                 op,
  input  logic [CACHE_ADDR_SIZE-1:0] addr1,
  input  logic [CACHE_ADDR_SIZE-1:0] addr2,
  input  logic [WIDTH_ADDR_SIZE-1:0] param1,
  input  logic [WIDTH_ADDR_SIZE-1:0] lane,
  output logic [CACHE_ADDR_SIZE-1:0] mat,
  output logic [WIDTH_ADDR_SIZE-1:0] row,
  output logic [WIDTH_ADDR_SIZE-1:0] col,
  output logic                       en
);

  logic w_unused;
  assign w_unused = ^addr2;

`ifdef MAT_CACHE_DIAG_EN
  // One extra bit so the split test sees the carry before any wrap.
  logic [WIDTH_ADDR_SIZE:0] w_sum;
  assign w_sum = {1'b0, lane} + {1'b0, param1};
`endif

  always_comb begin
    mat = addr1;
    row = '0;
    col = '0;
    en  = 1'b0;
    case (op)
      RD_ROW: begin
        row = param1;
        col = lane;
        en  = 1'b1;
      end
      RD_COL: begin
        row = lane;
        col = param1;
        en  = 1'b1;
      end
`ifdef MAT_CACHE_DIAG_EN
      RD_DIAG: begin
        row = lane;
        col = w_sum[WIDTH_ADDR_SIZE-1:0];
        en  = 1'b1;
      end
      RD_DIAG_SPLIT: begin
        // Low bits equal i+p1-WIDTH when the sum overflows WIDTH.
        mat = w_sum[WIDTH_ADDR_SIZE] ? addr2 : addr1;
        row = lane;
        col = w_sum[WIDTH_ADDR_SIZE-1:0];
        en  = 1'b1;
      end
`endif
      default: en = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mat_cache.sv
// ============================================================================
// Module : mat_cache
// Scratch-pad of CACHE_SIZE WIDTHxWIDTH word matrices; combinational vector
// read, clocked vector write. Optional feature macro: MAT_CACHE_DIAG_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mat_cache
  import mat_pkg::*;
#(
  parameter int WIDTH           = 16,
  parameter int CACHE_SIZE      = 8,
  parameter int WIDTH_ADDR_SIZE = $clog2(WIDTH),
  parameter int CACHE_ADDR_SIZE = $clog2(CACHE_SIZE)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [2:0]                       read_op,
  input  logic [CACHE_ADDR_SIZE-1:0]       read_addr1,
  input  logic [CACHE_ADDR_SIZE-1:0]       read_addr2,
  input  logic [WIDTH_ADDR_SIZE-1:0]       read_param1,
  input  logic [WIDTH_ADDR_SIZE-1:0]       read_param2,
  input  logic [2:0]                       write_op,
  input  logic [CACHE_ADDR_SIZE-1:0]       write_addr1,
  input  logic [CACHE_ADDR_SIZE-1:0]       write_addr2,
  input  logic [WIDTH_ADDR_SIZE-1:0]       write_param1,
  input  logic [WIDTH_ADDR_SIZE-1:0]       write_param2,
  input  logic [WIDTH*MAT_WORD_BITS-1:0]   data_in,
  output logic [WIDTH*MAT_WORD_BITS-1:0]   data_out
);

  logic [MAT_WORD_BITS-1:0] r_mem [CACHE_SIZE][WIDTH][WIDTH];

  logic [CACHE_ADDR_SIZE-1:0] w_rd_mat [WIDTH];
  logic [WIDTH_ADDR_SIZE-1:0] w_rd_row [WIDTH];
  logic [WIDTH_ADDR_SIZE-1:0] w_rd_col [WIDTH];
  logic                       w_rd_en  [WIDTH];
  logic [CACHE_ADDR_SIZE-1:0] w_wr_mat [WIDTH];
  logic [WIDTH_ADDR_SIZE-1:0] w_wr_row [WIDTH];
  logic [WIDTH_ADDR_SIZE-1:0] w_wr_col [WIDTH];
  logic                       w_wr_en  [WIDTH];

  logic w_unused_params;
  assign w_unused_params = ^{read_param2, write_param2};

  // Read and write share the op encoding, so one lane mapper serves both.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    localparam logic [WIDTH_ADDR_SIZE-1:0] c_lane = WIDTH_ADDR_SIZE'(i);

    mat_cache_lane_map #(
      .WIDTH          (WIDTH),
      .CACHE_SIZE     (CACHE_SIZE),
      .WIDTH_ADDR_SIZE(WIDTH_ADDR_SIZE),
      .CACHE_ADDR_SIZE(CACHE_ADDR_SIZE)
    ) u_rd_map (
      .op    (read_op),
      .addr1 (read_addr1),
      .addr2 (read_addr2),
      .param1(read_param1),
      .lane  (c_lane),
      .mat   (w_rd_mat[i]),
      .row   (w_rd_row[i]),
      .col   (w_rd_col[i]),
      .en    (w_rd_en[i])
    );

    mat_cache_lane_map #(
      .WIDTH          (WIDTH),
      .CACHE_SIZE     (CACHE_SIZE),
      .WIDTH_ADDR_SIZE(WIDTH_ADDR_SIZE),
      .CACHE_ADDR_SIZE(CACHE_ADDR_SIZE)
    ) u_wr_map (
      .op    (write_op),
      .addr1 (write_addr1),
      .addr2 (write_addr2),
      .param1(write_param1),
      .lane  (c_lane),
      .mat   (w_wr_mat[i]),
      .row   (w_wr_row[i]),
      .col   (w_wr_col[i]),
      .en    (w_wr_en[i])
    );

    assign data_out[i*MAT_WORD_BITS +: MAT_WORD_BITS] =
      w_rd_en[i] ? r_mem[w_rd_mat[i]][w_rd_row[i]][w_rd_col[i]] : '0;
  end

  // Every op maps lanes to distinct elements, so per-lane writes never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CACHE_SIZE; c++)
        for (int r = 0; r < WIDTH; r++)
          for (int k = 0; k < WIDTH; k++)
            r_mem[c][r][k] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++)
        if (w_wr_en[i])
          r_mem[w_wr_mat[i]][w_wr_row[i]][w_wr_col[i]] <= data_in[i*MAT_WORD_BITS +: MAT_WORD_BITS];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mat_cache.sv
// ============================================================================
// Module : tb_mat_cache
// Scoreboard bench for mat_cache; expectations follow MAT_CACHE_DIAG_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mat_cache;
  import mat_pkg::*;

  localparam int W  = 16;
  localparam int CS = 8;
  localparam int WA = 4;
  localparam int CA = 3;
  localparam int DW = W * 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [2:0]    read_op = '0;
  logic [CA-1:0] read_addr1 = '0, read_addr2 = '0;
  logic [WA-1:0] read_param1 = '0, read_param2 = '0;
  logic [2:0]    write_op = '0;
  logic [CA-1:0] write_addr1 = '0, write_addr2 = '0;
  logic [WA-1:0] write_param1 = '0, write_param2 = '0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;

  mat_cache #(.WIDTH(W), .CACHE_SIZE(CS)) dut (
    .clk(clk), .rst_n(rst_n),
    .read_op(read_op), .read_addr1(read_addr1), .read_addr2(read_addr2),
    .read_param1(read_param1), .read_param2(read_param2),
    .write_op(write_op), .write_addr1(write_addr1), .write_addr2(write_addr2),
    .write_param1(write_param1), .write_param2(write_param2),
    .data_in(data_in), .data_out(data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [DW-1:0] exp;
  } exp_t;

  exp_t sb_q[$];
  logic do_check = 1'b0;
  int   checks = 0;
  int   failures = 0;

  // Monitor: one scoreboard entry per flagged cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (do_check) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_underflow: got=%h required=an expected entry", data_out);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        checks++;
        if (data_out !== e.exp) begin
          failures++;
          $display("FAIL %s: got=%h required=%h", e.name, data_out, e.exp);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
    do_check = 1'b0;
  endtask

  task automatic expect_out(input string nm, input logic [DW-1:0] e);
    exp_t x;
    x.name = nm;
    x.exp  = e;
    sb_q.push_back(x);
    do_check = 1'b1;
  endtask

  task automatic set_rd(input logic [2:0] op, input int a1, input int a2, input int p1);
    read_op     = op;
    read_addr1  = CA'(a1);
    read_addr2  = CA'(a2);
    read_param1 = WA'(p1);
    read_param2 = WA'(15 - p1);
  endtask

  task automatic set_wr(input logic [2:0] op, input int a1, input int a2, input int p1,
                        input logic [DW-1:0] d);
    write_op     = op;
    write_addr1  = CA'(a1);
    write_addr2  = CA'(a2);
    write_param1 = WA'(p1);
    write_param2 = WA'(p1 + 3);
    data_in      = d;
  endtask

  // IEEE-754 single bit pattern of a positive integer below 2^24.
  function automatic logic [31:0] f2b(input int n);
    int e;
    e = 0;
    while ((n >> (e + 1)) != 0) e++;
    return (32'(127 + e) << 23) | ((32'(n) << (23 - e)) & 32'h007F_FFFF);
  endfunction

  function automatic logic [DW-1:0] lane_set(input logic [DW-1:0] v, input int i,
                                             input logic [31:0] w);
    logic [DW-1:0] r;
    r = v;
    r[i*32 +: 32] = w;
    return r;
  endfunction

  initial begin
    logic [DW-1:0] v_float, v_haz, v_zero, v, v2;
    v_zero = '0;
    for (int i = 0; i < W; i++) begin
      v_float[i*32 +: 32] = f2b(i + 1);
      v_haz[i*32 +: 32]   = 32'hA000_0000 + 32'(i);
    end

    // Reset held: read is zero, a write is ignored.
    next_cycle();
    set_wr(WR_ROW, 3, 0, 5, v_float);
    set_rd(RD_ROW, 3, 0, 5);
    expect_out("reset_row_read", v_zero);
    next_cycle();
    set_wr(WR_NONE, 0, 0, 0, v_zero);
    expect_out("reset_write_ignored", v_zero);
    rst_n = 1'b1;

    // ROW write; in the write cycle the target still reads zero.
    next_cycle();
    set_wr(WR_ROW, 2, 0, 4, v_float);
    set_rd(RD_ROW, 2, 0, 4);
    expect_out("first_write_cycle_old", v_zero);
    next_cycle();
    set_wr(WR_NONE, 0, 0, 0, v_zero);
    set_rd(RD_COL, 2, 0, 7);
    expect_out("col_read_after_row_write", lane_set(v_zero, 4, 32'h4100_0000));
    next_cycle();
    set_rd(RD_ROW, 2, 0, 4);
    expect_out("row_readback", v_float);

    // Same-cycle hazard: old value now, new value after the edge.
    next_cycle();
    set_wr(WR_ROW, 2, 0, 4, v_haz);
    set_rd(RD_ROW, 2, 0, 4);
    expect_out("hazard_old", v_float);
    next_cycle();
    set_wr(WR_NONE, 0, 0, 0, v_zero);
    expect_out("hazard_new", v_haz);

    // Unused op codes: read 5 is zero, write 6 changes nothing.
    next_cycle();
    set_rd(3'd5, 2, 0, 4);
    set_wr(3'd6, 2, 0, 4, v_float);
    expect_out("read_op5_zero", v_zero);
    next_cycle();
    set_wr(WR_NONE, 0, 0, 0, v_zero);
    set_rd(RD_ROW, 2, 0, 4);
    expect_out("write_op6_no_change", v_haz);

    // Matrix 1 = 16r+k, matrix 0 = 100+k.
    for (int r = 0; r < W; r++) begin
      next_cycle();
      for (int k = 0; k < W; k++) v[k*32 +: 32] = 32'(16 * r + k);
      set_wr(WR_ROW, 1, 0, r, v);
    end
    for (int r = 0; r < W; r++) begin
      next_cycle();
      for (int k = 0; k < W; k++) v[k*32 +: 32] = 32'(100 + k);
      set_wr(WR_ROW, 0, 0, r, v);
    end
    next_cycle();
    set_wr(WR_NONE, 0, 0, 0, v_zero);
    for (int i = 0; i < W; i++) v[i*32 +: 32] = 32'(16 * i + 5);
    set_rd(RD_COL, 1, 0, 5);
    expect_out("col_read_m1_c5", v);

    next_cycle();
    set_rd(RD_DIAG, 1, 0, 3);
`ifdef MAT_CACHE_DIAG_EN
    for (int i = 0; i < W; i++) v[i*32 +: 32] = 32'(16 * i + ((i + 3) % 16));
    v[15*32 +: 32] = 32'd242;
`else
    v = v_zero;
`endif
    expect_out("diag_m1_p3", v);

    // Matrix 1 becomes 200+k for the split test.
    for (int r = 0; r < W; r++) begin
      next_cycle();
      for (int k = 0; k < W; k++) v[k*32 +: 32] = 32'(200 + k);
      set_wr(WR_ROW, 1, 0, r, v);
    end
    next_cycle();
    set_wr(WR_NONE, 0, 0, 0, v_zero);
    set_rd(RD_DIAG_SPLIT, 0, 1, 14);
`ifdef MAT_CACHE_DIAG_EN
    v = v_zero;
    v = lane_set(v, 0, 32'd114);
    v = lane_set(v, 1, 32'd115);
    for (int i = 2; i < W; i++) v[i*32 +: 32] = 32'(200 + i - 2);
    v = lane_set(v, 15, 32'd213);
`else
    v = v_zero;
`endif
    expect_out("diag_split_a0_a1_p14", v);

    // DIAG write into matrix 3 lands on [i][(i+1) mod 16]; row 2 holds lane 2 at col 3.
    next_cycle();
    for (int i = 0; i < W; i++) v2[i*32 +: 32] = 32'h0000_5000 + 32'(i);
    set_wr(WR_DIAG, 3, 0, 1, v2);
    set_rd(RD_NONE, 0, 0, 0);
    expect_out("read_none_zero", v_zero);
    next_cycle();
    set_wr(WR_NONE, 0, 0, 0, v_zero);
    set_rd(RD_ROW, 3, 0, 2);
`ifdef MAT_CACHE_DIAG_EN
    v = lane_set(v_zero, 3, 32'h0000_5002);
`else
    v = v_zero;
`endif
    expect_out("diag_write_row2", v);

    // Mid-stream reset: storage clears at once, the write edge under reset is lost.
    next_cycle();
    set_wr(WR_ROW, 5, 0, 0, v_float);
    set_rd(RD_ROW, 2, 0, 4);
    expect_out("pre_reset_contents", v_haz);
    next_cycle();
    rst_n = 1'b0;
    set_wr(WR_ROW, 5, 0, 1, v_haz);
    expect_out("reset_clears_m2", v_zero);
    next_cycle();
    set_wr(WR_NONE, 0, 0, 0, v_zero);
    set_rd(RD_ROW, 5, 0, 0);
    expect_out("reset_clears_m5_r0", v_zero);
    rst_n = 1'b1;
    next_cycle();
    set_rd(RD_ROW, 5, 0, 1);
    expect_out("pending_write_dropped", v_zero);
    set_wr(WR_COL, 5, 0, 1, v_float);
    next_cycle();
    set_wr(WR_NONE, 0, 0, 0, v_zero);
    set_rd(RD_COL, 5, 0, 1);
    expect_out("write_after_reset", v_float);

    next_cycle();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got=%0d required=0 entries", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout required=completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
